// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
// master = operand source/result sink, slave = controller.
interface serial_add_ctrl_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         in_sub;
`endif
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, res_ready,
    input  in_ready, res_valid, sum, cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, res_ready,
    output in_ready, res_valid, sum, cout
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, res_ready,
    input  in_ready, res_valid, sum, cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, res_ready,
    output in_ready, res_valid, sum, cout
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds one external full adder LSB-first.
// Ports: clk, rst_n (sync, active low), bus (operands/result), busy,
// fa_a/fa_b/fa_cin to the adder cell, fa_s/fa_cout back from it.
// Optional SERIAL_ADD_SUB_EN adds bus.in_sub for A-B (A+~B+1).
module serial_add_ctrl #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus,
  output logic             busy,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST = IW'(W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic          sub_q;
  logic          sub_in;

  logic st_idle;
  logic st_run;
  logic st_done;

  assign st_idle = (state == S_IDLE);
  assign st_run  = (state == S_RUN);
  assign st_done = (state == S_DONE);

`ifdef SERIAL_ADD_SUB_EN
  assign sub_in = bus.in_sub;
`else
  assign sub_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        st_idle: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            sub_q   <= sub_in;
            // subtract seeds the +1 of two's complement
            carry_q <= sub_in ? 1'b1 : bus.in_cin;
            idx     <= '0;
            sum_q   <= '0;
            state   <= S_RUN;
          end
        end
        st_run: begin
          sum_q[idx] <= fa_s;
          carry_q    <= fa_cout;
          if (idx == LAST) state <= S_DONE;
          else             idx   <= idx + 1'b1;
        end
        st_done: begin
          if (bus.res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = st_idle;
  assign bus.res_valid = st_done;
  assign bus.sum       = st_done ? sum_q : '0;
  assign bus.cout      = st_done & carry_q;
  assign busy          = st_run;
  assign fa_a          = st_run & a_q[idx];
  assign fa_b          = st_run & (b_q[idx] ^ sub_q);
  assign fa_cin        = st_run & carry_q;
endmodule
